cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//  Sequences the multi-cycle CPU from the board clock: turns a debounced step button
//  and a run switch into single-cycle cpu_ce pulses. Stops on a PC breakpoint or on OF.
//  Sits between the button debouncer / switches and the CPU clock-enable.
//  Status outputs feed the seven-segment display mux.
// PARAMETERS
//  RATE_DIV  25000  board-clock cycles between cpu_ce pulses in RUN (1 kHz @ 25 MHz); >=2
//  CNT_W     16     width of the retired-step counter
// PORTS
//  clk        in   1      board clock (25 MHz); only clock
//  rst        in   1      asynchronous, active-low reset
//  step_btn   in   1      debounced step button, level; rising edge = one step request
//  run_sw     in   1      1 = free-run at RATE_DIV rate, 0 = single-step mode
//  clr        in   1      synchronous clear: HALT->IDLE, zero step_cnt
//  bp_en      in   1      breakpoint enable
//  bp_addr    in   32     breakpoint PC
//  pc         in   32     current CPU PC
//  of_in      in   1      CPU overflow flag
//  cpu_ce     out  1      one-cycle CPU clock-enable pulse
//  state      out  2      00 IDLE, 01 STEP, 10 RUN, 11 HALT
//  halt_cause out  2      00 none, 01 breakpoint, 10 overflow, 11 both
//  step_cnt   out  CNT_W  cpu_ce pulses since reset/clr; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cpu_ce=0, halt_cause=00, step_cnt=0, divider=0,
//   edge register=0, resume flag=0.
//  Edge detect: step_rise = step_btn & ~step_btn_q (step_btn_q registered every cycle).
//  bp_hit = bp_en & (pc==bp_addr), combinational.
//  IDLE: run_sw=1 -> RUN and set resume; else step_rise -> STEP.
//  STEP: cpu_ce=1 for exactly this one cycle; step_cnt++; next cycle -> IDLE.
//   Single step ignores bp_hit; an overflow is flagged only after the step retires.
//  RUN: divider counts 0..RATE_DIV-1. At terminal count:
//   - if bp_hit & ~resume -> HALT with cause 01, and no pulse;
//   - else cpu_ce=1, step_cnt++, clear resume.
//   run_sw=0 -> IDLE on the next cycle, with the divider cleared.
//   step_rise is ignored in RUN.
//  Resume: set on every entry to RUN so the PC parked on a breakpoint executes once.
//  Overflow: in IDLE or RUN, of_in=1 on the cycle after a cpu_ce pulse -> HALT.
//   halt_cause bit1=1; bit0 is set too if bp_hit also qualifies in that cycle.
//  HALT: cpu_ce=0. Only clr leaves HALT: clr -> IDLE, halt_cause=00, step_cnt=0.
//   run_sw and step_btn are ignored in HALT. run_sw still high after clr -> RUN next cycle.
//  clr in any other state: zero step_cnt and divider only; state unchanged.
//  Simultaneous clr and cpu_ce: clr wins, so step_cnt=0.
//  cpu_ce is registered and high for at most one cycle per request; never two in a row.
//  step_cnt saturates: no wrap, no further increment at all-ones.
//  Latency: step_rise -> cpu_ce is 1 cycle. RUN entry -> first pulse is RATE_DIV cycles.
//  Reset mid-RUN or mid-STEP: immediate return to reset values; a pending pulse is dropped.
// STRUCTURE
//  Shared package: state encoding (IDLE/STEP/RUN/HALT), halt_cause codes, default RATE_DIV.
//  Sub-module: rate_div_cnt (modulo-RATE_DIV counter with clear and terminal-count
//   output). The FSM, edge detect and counter logic stay in cpu_step_ctrl.
// TESTING
//  1 reset: hold rst=0 with inputs toggling -> cpu_ce=0, state=00, step_cnt=0, cause=00.
//  2 step: 3 step_btn rising edges, 10 cycles apart -> exactly 3 single-cycle cpu_ce
//    pulses, each 1 cycle after its edge; step_cnt=3; held button gives no repeats.
//  3 run rate: RATE_DIV=4, run_sw=1 for 20 cycles -> pulses at cycles 4,8,12,16,20
//    after entry; then run_sw=0 -> IDLE, no more pulses.
//  4 breakpoint: bp_en=1, bp_addr=0x10; model pc advances 4 per pulse from 0x0 -> 4
//    pulses, then HALT, cause=01, pc=0x10; clr then RUN -> the first pulse passes 0x10.
//  5 overflow: of_in=1 the cycle after the 2nd RUN pulse -> HALT, cause=10;
//    step_btn and run_sw ignored until clr -> IDLE, step_cnt=0.
//  6 edge cases: CNT_W=2 with 5 steps -> step_cnt stays 3; clr together with cpu_ce
//    -> step_cnt=0; rst=0 mid-RUN -> reset values at once, no pulse.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_step_ctrl_pkg
//   Shared definitions for the CPU step controller:
//   - state_e      : controller state encoding, also driven onto the state port
//   - CAUSE_*      : halt_cause codes shown on the seven-segment display
//   - DEFAULT_*    : default divider ratio (1 kHz @ 25 MHz) and counter width
//   - of_cause()   : halt cause for an overflow stop, folding in a breakpoint
// ----------------------------------------------------------------------------
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_OF   = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  localparam int DEFAULT_RATE_DIV = 25000;
  localparam int DEFAULT_CNT_W    = 16;

  // An overflow stop always reports the overflow bit; the breakpoint bit is
  // added when the PC also sits on an enabled breakpoint in that cycle.
  function automatic logic [1:0] of_cause(input logic bp_hit);
    return bp_hit ? CAUSE_BOTH : CAUSE_OF;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_rate_div_cnt.sv
// ----------------------------------------------------------------------------
// rate_div_cnt
//   Modulo-RATE_DIV counter that paces cpu_ce pulses in free-run mode.
//   Counts 0..RATE_DIV-1 while en is high, wraps to 0 after the terminal
//   count, and is forced to 0 by clr (clr has priority over en).
// Ports
//   clk  in  board clock
//   rst  in  asynchronous active-low reset
//   en   in  count enable
//   clr  in  synchronous clear to zero
//   tc   out high during the cycle the counter holds RATE_DIV-1 with en high
// ----------------------------------------------------------------------------
module rate_div_cnt
  import cpu_step_ctrl_pkg::*;
#(
  parameter int RATE_DIV = DEFAULT_RATE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DW-1:0] TC_VAL = DW'(RATE_DIV - 1);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  assign tc = en && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_step_ctrl
//   Sequences a multi-cycle CPU from the board clock. A debounced step button
//   issues single cpu_ce pulses; the run switch free-runs the CPU at one pulse
//   every RATE_DIV cycles. Execution stops (HALT) on a PC breakpoint or on the
//   CPU overflow flag, and only clr leaves HALT.
//
//   cpu_ce is a one-cycle strobe with no back-pressure: the CPU advances one
//   step on every clock edge that samples cpu_ce high. It is registered and is
//   never high in two consecutive cycles.
//
// Ports
//   clk         in   board clock (only clock)
//   rst         in   asynchronous active-low reset
//   step_btn    in   debounced step button level; rising edge = one step
//   run_sw      in   1 = free-run, 0 = single-step mode
//   clr         in   synchronous clear: HALT->IDLE, zero step_cnt/divider
//   bp_en       in   breakpoint enable
//   bp_addr     in   breakpoint PC
//   pc          in   current CPU PC
//   of_in       in   CPU overflow flag
//   cpu_ce      out  one-cycle CPU clock-enable pulse
//   state       out  00 IDLE, 01 STEP, 10 RUN, 11 HALT
//   halt_cause  out  00 none, 01 breakpoint, 10 overflow, 11 both
//   step_cnt    out  cpu_ce pulses since reset/clr, saturating
// ----------------------------------------------------------------------------
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int RATE_DIV = DEFAULT_RATE_DIV,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             clr,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             of_in,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] step_cnt
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic [1:0]         cause_q,  cause_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               resume_q, resume_d;
  logic               step_btn_q;
  // Delayed copy of cpu_ce: marks the cycle in which the CPU has just retired
  // a step, which is when its overflow flag is meaningful.
  logic               ce_prev_q;

  // --------------------------------------------------------------------------
  // Combinational qualifiers
  // --------------------------------------------------------------------------
  logic step_rise;
  logic bp_hit;
  logic of_trip;
  logic div_en;
  logic div_clr;
  logic div_tc;

  assign step_rise = step_btn & ~step_btn_q;
  assign bp_hit    = bp_en & (pc == bp_addr);
  assign of_trip   = ce_prev_q & of_in;

  // The divider only runs in RUN; holding it at zero everywhere else gives
  // exactly RATE_DIV cycles from RUN entry to the first pulse.
  assign div_en  = (state_q == ST_RUN);
  assign div_clr = clr | (state_q != ST_RUN);

  rate_div_cnt #(
    .RATE_DIV (RATE_DIV)
  ) u_rate_div_cnt (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .clr (div_clr),
    .tc  (div_tc)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;

    unique case (state_q)
      ST_IDLE: begin
        if (of_trip) begin
          state_d = ST_HALT;
          cause_d = of_cause(bp_hit);
        end else if (run_sw) begin
          // Resume lets a PC parked on the breakpoint execute once.
          state_d  = ST_RUN;
          resume_d = 1'b1;
        end else if (step_rise) begin
          state_d  = ST_STEP;
          cpu_ce_d = 1'b1;
        end
      end

      ST_STEP: begin
        // The pulse was issued on entry; a single step ignores breakpoints.
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        if (of_trip) begin
          state_d = ST_HALT;
          cause_d = of_cause(bp_hit);
        end else if (!run_sw) begin
          state_d = ST_IDLE;
        end else if (div_tc) begin
          if (bp_hit && !resume_q) begin
            state_d = ST_HALT;
            cause_d = CAUSE_BP;
          end else begin
            cpu_ce_d = 1'b1;
            resume_d = 1'b0;
          end
        end
      end

      ST_HALT: begin
        if (clr) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retired-step counter saturates at all-ones; clr overrides an increment
    // that lands in the same cycle.
    if (cpu_ce_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr) begin
      cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cpu_ce_q   <= 1'b0;
      cause_q    <= CAUSE_NONE;
      cnt_q      <= '0;
      resume_q   <= 1'b0;
      step_btn_q <= 1'b0;
      ce_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= cpu_ce_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      resume_q   <= resume_d;
      step_btn_q <= step_btn;
      ce_prev_q  <= cpu_ce_q;
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//   Directed bench for cpu_step_ctrl with RATE_DIV=4. Stimulus tasks push the
//   expected (cycle, step_cnt) of each cpu_ce pulse into exp_q; a monitor on
//   the falling edge pops and compares whenever cpu_ce is high. A second
//   instance with CNT_W=2 shares all inputs and is used for saturation.
// ----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

  localparam int RATE_DIV = 4;
  localparam int CNT_W    = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT inputs / outputs
  logic             step_btn, run_sw, clr, bp_en, of_in;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             cpu_ce;
  logic [1:0]       state, halt_cause;
  logic [CNT_W-1:0] step_cnt;

  logic             sat_ce;
  logic [1:0]       sat_state, sat_cause;
  logic [1:0]       sat_cnt;

  cpu_step_ctrl #(.RATE_DIV(RATE_DIV), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .run_sw     (run_sw),
    .clr        (clr),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .of_in      (of_in),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .halt_cause (halt_cause),
    .step_cnt   (step_cnt)
  );

  cpu_step_ctrl #(.RATE_DIV(RATE_DIV), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .run_sw     (run_sw),
    .clr        (clr),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .of_in      (of_in),
    .cpu_ce     (sat_ce),
    .state      (sat_state),
    .halt_cause (sat_cause),
    .step_cnt   (sat_cnt)
  );

  // Minimal CPU model: PC advances by 4 on every enabled clock edge.
  logic pc_rst;
  always @(posedge clk) begin
    if (pc_rst) pc <= 32'h0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  // Scoreboard
  logic [47:0]      exp_q[$];
  logic [47:0]      mon_e;
  logic [CNT_W-1:0] exp_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [15:0] cnt);
    exp_q.push_back({32'(at), cnt});
  endtask

  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), mon_e[47:16]);
        check("pulse_step_cnt", 32'(step_cnt), 32'(mon_e[15:0]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m;
    step_btn = 0; run_sw = 0; clr = 0; bp_en = 0; of_in = 0;
    bp_addr = 32'h0; pc_rst = 1; exp_cnt = '0;

    // ---- 1: reset held with inputs toggling ------------------------------
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      step_btn = ~step_btn;
      run_sw   = ~run_sw;
      of_in    = ~of_in;
      clr      = i[0];
      check("reset_cpu_ce", 32'(cpu_ce), 0);
    end
    check("reset_state", 32'(state), 0);
    check("reset_step_cnt", 32'(step_cnt), 0);
    check("reset_cause", 32'(halt_cause), 0);
    step_btn = 0; run_sw = 0; of_in = 0; clr = 0;
    tick();
    rst = 1;
    tick();
    tick();

    // ---- 2: three single steps, button held 5 cycles ---------------------
    for (int i = 0; i < 3; i++) begin
      k = cyc;
      step_btn = 1;
      exp_cnt++;
      expect_pulse(k + 1, exp_cnt);
      goto_cyc(k + 5);
      step_btn = 0;
      goto_cyc(k + 10);
    end
    check("step_cnt_after_3", 32'(step_cnt), 3);
    check("step_state_idle", 32'(state), 0);

    // ---- 3: free-run rate ------------------------------------------------
    k = cyc;
    run_sw = 1;
    for (int n = 1; n <= 5; n++) begin
      exp_cnt++;
      expect_pulse(k + 1 + 4 * n, exp_cnt);
    end
    goto_cyc(k + 21);
    check("run_state", 32'(state), 2);
    run_sw = 0;
    goto_cyc(k + 30);
    check("run_exit_idle", 32'(state), 0);
    check("run_step_cnt", 32'(step_cnt), 8);

    // ---- 4: breakpoint ---------------------------------------------------
    bp_en = 1; bp_addr = 32'h10; pc_rst = 1; clr = 1;
    tick();
    clr = 0; pc_rst = 0; exp_cnt = '0;
    check("clr_idle_step_cnt", 32'(step_cnt), 0);
    k = cyc;
    run_sw = 1;
    for (int n = 1; n <= 4; n++) begin
      exp_cnt++;
      expect_pulse(k + 1 + 4 * n, exp_cnt);
    end
    goto_cyc(k + 23);
    check("bp_state_halt", 32'(state), 3);
    check("bp_cause", 32'(halt_cause), 1);
    check("bp_pc", pc, 32'h10);
    check("bp_step_cnt", 32'(step_cnt), 4);
    m = cyc;
    clr = 1;
    tick();
    clr = 0;
    exp_cnt = '0;
    check("bp_clr_state", 32'(state), 0);
    check("bp_clr_cause", 32'(halt_cause), 0);
    check("bp_clr_step_cnt", 32'(step_cnt), 0);
    exp_cnt++;
    expect_pulse(m + 6, exp_cnt);
    goto_cyc(m + 6);
    run_sw = 0;
    goto_cyc(m + 10);
    check("bp_resume_pc", pc, 32'h14);
    check("bp_resume_idle", 32'(state), 0);

    // ---- 5: overflow -----------------------------------------------------
    bp_en = 0;
    k = cyc;
    run_sw = 1;
    for (int n = 1; n <= 2; n++) begin
      exp_cnt++;
      expect_pulse(k + 1 + 4 * n, exp_cnt);
    end
    goto_cyc(k + 10);
    of_in = 1;
    tick();
    of_in = 0;
    check("of_state_halt", 32'(state), 3);
    check("of_cause", 32'(halt_cause), 2);
    for (int i = 0; i < 8; i++) begin
      step_btn = ~step_btn;
      tick();
    end
    step_btn = 0;
    tick();
    check("of_halt_held", 32'(state), 3);
    check("of_step_cnt", 32'(step_cnt), 3);
    run_sw = 0;
    clr = 1;
    tick();
    clr = 0;
    exp_cnt = '0;
    check("of_clr_state", 32'(state), 0);
    check("of_clr_step_cnt", 32'(step_cnt), 0);
    check("of_clr_cause", 32'(halt_cause), 0);

    // ---- 6a: saturation on the CNT_W=2 instance --------------------------
    for (int i = 0; i < 5; i++) begin
      k = cyc;
      step_btn = 1;
      exp_cnt++;
      expect_pulse(k + 1, exp_cnt);
      goto_cyc(k + 2);
      step_btn = 0;
      goto_cyc(k + 4);
    end
    check("sat_main_cnt", 32'(step_cnt), 5);
    check("sat_cnt", 32'(sat_cnt), 3);
    check("sat_state", 32'(sat_state), 0);
    check("sat_cause", 32'(sat_cause), 0);
    check("sat_ce_idle", 32'(sat_ce), 0);

    // ---- 6b: clr together with a pulse -----------------------------------
    k = cyc;
    step_btn = 1;
    clr = 1;
    exp_cnt = '0;
    expect_pulse(k + 1, exp_cnt);
    tick();
    tick();
    clr = 0;
    step_btn = 0;
    check("clr_ce_step_cnt", 32'(step_cnt), 0);
    tick();

    // ---- 6c: reset mid-RUN drops the pending pulse -----------------------
    k = cyc;
    run_sw = 1;
    exp_cnt++;
    expect_pulse(k + 5, exp_cnt);
    goto_cyc(k + 8);
    rst = 0;
    #1;
    check("rst_run_cpu_ce", 32'(cpu_ce), 0);
    check("rst_run_state", 32'(state), 0);
    check("rst_run_step_cnt", 32'(step_cnt), 0);
    check("rst_run_cause", 32'(halt_cause), 0);
    run_sw = 0;
    tick();
    tick();
    tick();
    rst = 1;
    goto_cyc(cyc + 5);
    check("rst_release_idle", 32'(state), 0);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
